shift_left_seq: RTL

//   Multi-cycle logical left shifter for the ALU datapath; complement of the combinational right shifter.

---
 rtl/shift_left_seq_pkg.sv | 17 +
 rtl/shift_left_seq_lane.sv | 41 ++++
 rtl/shift_left_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/shift_left_seq_pkg.sv
// Shared definitions for the multi-cycle left shifter.
// Holds the controller state encoding and the default operand and shift-amount widths.
// The right shifter uses the same defaults, so both sides of the ALU op mux agree.
package shift_left_seq_pkg;

    // Default operand width and shift-amount width
    localparam int DEF_WIDTH = 8;
    localparam int DEF_AW    = 3;

    // Controller states, 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_left_seq_lane.sv
// One operand lane: a WIDTH-bit register that can load a value or shift left by one.
// Latency: load and shift both take effect on the next rising edge; holds otherwise.
// Backpressure: none; the controller sequences load and shift.
module shift_left_seq_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_dat,
    output logic [WIDTH-1:0] lane_dat,
    output logic             msb_out
);

    logic [WIDTH-1:0] lane_d;
    logic [WIDTH-1:0] lane_q;

    // Next value: load has priority over shift; the LSB is zero-filled
    always_comb begin
        lane_d = lane_q;
        if (load) begin
            lane_d = load_dat;
        end else if (shift) begin
            lane_d = {lane_q[WIDTH-2:0], 1'b0};
        end
    end

    // Lane register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign lane_dat = lane_q;
    assign msb_out  = lane_q[WIDTH-1];

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: F = A << amt, G = B << amt, one bit per clock.
// Latency: done pulses amt+1 edges after the edge that samples start (amt=0 -> 1).
// Backpressure: start is only accepted in IDLE; start while busy is ignored.
module shift_left_seq
    import shift_left_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] G,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    state_t          state_d, state_q;
    logic [AW-1:0]   count_d, count_q;
    logic            cout_d,  cout_q;

    logic            accept;
    logic            lane_load;
    logic            lane_shift;
    logic            a_msb;
    logic            b_msb;
    logic            last_shift;

    // Operands are captured only when idle so a start during an operation cannot disturb it
    assign accept     = start && (state_q == S_IDLE);
    assign lane_load  = accept;
    assign lane_shift = (state_q == S_SHIFT);
    assign last_shift = (state_q == S_SHIFT) && (count_q == AW'(1));

    // A lane: drives F and supplies the bit that falls off the top into cout
    shift_left_seq_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk      (clk),
        .reset    (reset),
        .load     (lane_load),
        .shift    (lane_shift),
        .load_dat (A),
        .lane_dat (F),
        .msb_out  (a_msb)
    );

    // B lane: drives G; its MSB is not observed at the ports
    shift_left_seq_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk      (clk),
        .reset    (reset),
        .load     (lane_load),
        .shift    (lane_shift),
        .load_dat (B),
        .lane_dat (G),
        .msb_out  (b_msb)
    );

    // State, remaining-shift counter and carry-out registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic: a zero shift skips straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (last_shift) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter and carry-out: cout tracks the bit leaving A's MSB on each shift
    always_comb begin
        count_d = count_q;
        cout_d  = cout_q;
        if (accept) begin
            count_d = amt;
            cout_d  = 1'b0;
        end else if (state_q == S_SHIFT) begin
            count_d = count_q - AW'(1);
            cout_d  = a_msb;
        end
    end

    // Status outputs decoded from the state register only
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SHIFT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign cout = cout_q;

    // The B lane MSB is deliberately unobserved
    logic unused_b_msb;
    assign unused_b_msb = b_msb;

endmodule
